// File: rtl/score_level_unit_pkg.sv
// Shared game package: default parameter values, converter state encoding
// and the line-clear points table.
package score_level_unit_pkg;

  localparam int SLU_SCORE_W         = 13;
  localparam int SLU_SCORE_MAX       = 8191;
  localparam int SLU_DIGITS          = 4;
  localparam int SLU_WIN_THRESH      = 100;
  localparam int SLU_LINES_PER_LEVEL = 10;
  localparam int SLU_MAX_LEVEL       = 15;
  localparam int SLU_BASE_TICKS      = 50_000_000;
  localparam int SLU_TICK_STEP       = 3_000_000;
  localparam int SLU_MIN_TICKS       = 5_000_000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } bcd_state_t;

  // Base points for a clear of n lines; 0 marks an illegal line count.
  function automatic logic [3:0] line_points(input logic [2:0] n);
    case (n)
      3'd1:    return 4'd1;
      3'd2:    return 4'd3;
      3'd3:    return 4'd5;
      3'd4:    return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/score_level_unit_if.sv
// Game-event inputs and score/level/gravity/BCD outputs of the score unit.
interface score_level_unit_if #(
  parameter int SCORE_W = 13,
  parameter int DIGITS  = 4
);
  logic                  game_start;
  logic                  clr_valid;
  logic [2:0]            clr_lines;
  logic [SCORE_W-1:0]    score;
  logic [3:0]            level;
  logic                  win;
  logic                  drop_tick;
  logic [4*DIGITS-1:0]   bcd;
  logic                  bcd_valid;

  modport master (
    output game_start, clr_valid, clr_lines,
    input  score, level, win, drop_tick, bcd, bcd_valid
  );

  modport slave (
    input  game_start, clr_valid, clr_lines,
    output score, level, win, drop_tick, bcd, bcd_valid
  );
endinterface

// File: rtl/score_level_unit_bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter. Starts whenever the input
// differs from the last converted value; bcd only ever shows full results.
module bin2bcd_seq
  import score_level_unit_pkg::*;
#(
  parameter int SCORE_W = 13,
  parameter int DIGITS  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SCORE_W-1:0]  bin,
  output logic [4*DIGITS-1:0] bcd,
  output logic                bcd_valid
);
  localparam int CW = $clog2(SCORE_W + 1);

  bcd_state_t          state;
  logic [SCORE_W-1:0]  sh;
  logic [SCORE_W-1:0]  last;
  logic [4*DIGITS-1:0] acc;
  logic [4*DIGITS-1:0] acc_adj;
  logic [CW-1:0]       cnt;
  logic                pending;

  // Add 3 to every digit that is 5 or more before the next shift.
  always_comb begin
    acc_adj = acc;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (acc[4*d +: 4] >= 4'd5) acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
    end
  end

  // Converter FSM with registered bcd and one-cycle bcd_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sh        <= '0;
      last      <= '0;
      acc       <= '0;
      cnt       <= '0;
      pending   <= 1'b0;
      bcd       <= '0;
      bcd_valid <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pending || (bin != last)) begin
            sh      <= bin;
            last    <= bin;
            acc     <= '0;
            cnt     <= '0;
            pending <= 1'b0;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          acc <= {acc_adj[4*DIGITS-2:0], sh[SCORE_W-1]};
          sh  <= {sh[SCORE_W-2:0], 1'b0};
          cnt <= cnt + CW'(1);
          if (bin != last) pending <= 1'b1;
          if (cnt == CW'(SCORE_W - 1)) state <= ST_DONE;
        end
        ST_DONE: begin
          bcd       <= acc;
          bcd_valid <= 1'b1;
          if (bin != last) pending <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/score_level_unit.sv
// Score, line/level tracking, win flag, gravity tick generator and BCD
// image of the score for a falling-block game.
module score_level_unit
  import score_level_unit_pkg::*;
#(
  parameter int SCORE_W         = SLU_SCORE_W,
  parameter int SCORE_MAX       = SLU_SCORE_MAX,
  parameter int DIGITS          = SLU_DIGITS,
  parameter int WIN_THRESH      = SLU_WIN_THRESH,
  parameter int LINES_PER_LEVEL = SLU_LINES_PER_LEVEL,
  parameter int MAX_LEVEL       = SLU_MAX_LEVEL,
  parameter int BASE_TICKS      = SLU_BASE_TICKS,
  parameter int TICK_STEP       = SLU_TICK_STEP,
  parameter int MIN_TICKS       = SLU_MIN_TICKS
) (
  input logic               clk,
  input logic               rst_n,
  score_level_unit_if.slave bus
);
  // Holds a residue below LINES_PER_LEVEL plus one 4-line clear.
  localparam int LW = $clog2(LINES_PER_LEVEL + 5);

  logic [SCORE_W-1:0]  score_q;
  logic [3:0]          level_q;
  logic [LW-1:0]       lines_q;
  logic                win_q;
  logic                tick_q;
  logic [31:0]         drop_cnt;
  logic [3:0]          pts;
  logic                ev;
  logic                lvl_up;
  int                  sum_i;
  int                  lines_i;
  int                  period_i;

  // Points for a legal event, scaled by the pre-event level and saturated.
  always_comb begin
    pts   = line_points(bus.clr_lines);
    ev    = bus.clr_valid && (pts != 4'd0);
    sum_i = int'(score_q) + int'(pts) * (int'(level_q) + 1);
    if (sum_i > SCORE_MAX) sum_i = SCORE_MAX;
  end

  // Line accumulation with a single level step per event.
  always_comb begin
    lvl_up  = 1'b0;
    lines_i = int'(lines_q) + int'(bus.clr_lines);
    if (lines_i >= LINES_PER_LEVEL) begin
      lines_i = lines_i - LINES_PER_LEVEL;
      lvl_up  = 1'b1;
    end
  end

  // Drop period for the current level, floored at MIN_TICKS.
  always_comb begin
    period_i = BASE_TICKS - int'(level_q) * TICK_STEP;
    if (period_i < MIN_TICKS) period_i = MIN_TICKS;
  end

  // Score, line counter and level; game_start overrides a coincident event.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.game_start) begin
      score_q <= '0;
      level_q <= '0;
      lines_q <= '0;
    end else if (ev) begin
      score_q <= SCORE_W'(sum_i);
      lines_q <= LW'(lines_i);
      if (lvl_up && (int'(level_q) < MAX_LEVEL)) level_q <= level_q + 4'd1;
    end
  end

  // Win flag follows the registered score one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) win_q <= 1'b0;
    else        win_q <= (int'(score_q) > WIN_THRESH);
  end

  // Gravity down-counter; the level is sampled only when it reloads.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.game_start) begin
      drop_cnt <= 32'(BASE_TICKS - 1);
      tick_q   <= 1'b0;
    end else if (drop_cnt == 32'd0) begin
      drop_cnt <= 32'(period_i - 1);
      tick_q   <= 1'b1;
    end else begin
      drop_cnt <= drop_cnt - 32'd1;
      tick_q   <= 1'b0;
    end
  end

  bin2bcd_seq #(
    .SCORE_W (SCORE_W),
    .DIGITS  (DIGITS)
  ) u_bcd (
    .clk       (clk),
    .rst_n     (rst_n),
    .bin       (score_q),
    .bcd       (bus.bcd),
    .bcd_valid (bus.bcd_valid)
  );

  assign bus.score     = score_q;
  assign bus.level     = level_q;
  assign bus.win       = win_q;
  assign bus.drop_tick = tick_q;

endmodule

// File: tb/tb_score_level_unit.sv
// Directed bench: instance A uses default parameters, instance B a fast
// gravity / 9999-ceiling configuration.
module tb_score_level_unit;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  score_level_unit_if #(.SCORE_W(13), .DIGITS(4)) ifa ();
  score_level_unit_if #(.SCORE_W(14), .DIGITS(4)) ifb ();

  score_level_unit u_dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));

  score_level_unit #(
    .SCORE_W(14), .SCORE_MAX(9999), .DIGITS(4), .WIN_THRESH(100),
    .LINES_PER_LEVEL(1), .MAX_LEVEL(15),
    .BASE_TICKS(20), .TICK_STEP(5), .MIN_TICKS(8)
  ) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic ev_a(input logic [2:0] n);
    @(negedge clk); ifa.clr_valid = 1'b1; ifa.clr_lines = n;
    @(negedge clk); ifa.clr_valid = 1'b0; ifa.clr_lines = 3'd0;
  endtask

  task automatic ev_b(input logic [2:0] n);
    @(negedge clk); ifb.clr_valid = 1'b1; ifb.clr_lines = n;
    @(negedge clk); ifb.clr_valid = 1'b0; ifb.clr_lines = 3'd0;
  endtask

  task automatic gs_a();
    @(negedge clk); ifa.game_start = 1'b1;
    @(negedge clk); ifa.game_start = 1'b0;
  endtask

  task automatic gs_b();
    @(negedge clk); ifb.game_start = 1'b1;
    @(negedge clk); ifb.game_start = 1'b0;
  endtask

  // Watches instance A for n cycles, reporting pulse count and first/last bcd.
  task automatic watch_bcd_a(input int n, output int cnt, output logic [15:0] first, output logic [15:0] last);
    cnt = 0; first = 16'hxxxx; last = 16'hxxxx;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ifa.bcd_valid) begin
        if (cnt == 0) first = ifa.bcd;
        last = ifa.bcd;
        cnt++;
      end
    end
  endtask

  task automatic wait_tick_b(output int t);
    t = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ifb.drop_tick) begin t = cyc; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    tests++; if (ifa.score !== 13'd0) begin fails++; $display("FAIL reset_score: got %0d want 0", ifa.score); end
    tests++; if (ifa.level !== 4'd0) begin fails++; $display("FAIL reset_level: got %0d want 0", ifa.level); end
    tests++; if (ifa.win !== 1'b0) begin fails++; $display("FAIL reset_win: got %b want 0", ifa.win); end
    tests++; if (ifa.drop_tick !== 1'b0) begin fails++; $display("FAIL reset_tick: got %b want 0", ifa.drop_tick); end
    tests++; if (ifa.bcd !== 16'h0000 || ifa.bcd_valid !== 1'b0) begin fails++; $display("FAIL reset_bcd: got %h/%b want 0000/0", ifa.bcd, ifa.bcd_valid); end
    tests++; if (ifb.score !== 14'd0 || ifb.drop_tick !== 1'b0) begin fails++; $display("FAIL reset_b: got %0d/%b want 0/0", ifb.score, ifb.drop_tick); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset_abort();
    int cnt; logic [15:0] f, l;
    ev_a(3'd1);
    tests++; if (ifa.score !== 13'd1) begin fails++; $display("FAIL abort_pre_score: got %0d want 1", ifa.score); end
    idle(3);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    watch_bcd_a(40, cnt, f, l);
    tests++; if (cnt != 0) begin fails++; $display("FAIL abort_no_valid: got %0d pulses want 0", cnt); end
    tests++; if (ifa.bcd !== 16'h0000 || ifa.score !== 13'd0) begin fails++; $display("FAIL abort_state: got bcd %h score %0d want 0000/0", ifa.bcd, ifa.score); end
  endtask

  task automatic test_level_up();
    for (int i = 0; i < 10; i++) ev_a(3'd1);
    tests++; if (ifa.score !== 13'd10) begin fails++; $display("FAIL lvl_score10: got %0d want 10", ifa.score); end
    tests++; if (ifa.level !== 4'd1) begin fails++; $display("FAIL lvl_level1: got %0d want 1", ifa.level); end
    tests++; if (ifa.win !== 1'b0) begin fails++; $display("FAIL lvl_win0: got %b want 0", ifa.win); end
    ev_a(3'd4);
    tests++; if (ifa.score !== 13'd26) begin fails++; $display("FAIL lvl_score26: got %0d want 26", ifa.score); end
  endtask

  task automatic test_win();
    int cnt; logic [15:0] f, l;
    ev_a(3'd4); ev_a(3'd4); ev_a(3'd4);
    tests++; if (ifa.score !== 13'd82 || ifa.level !== 4'd2) begin fails++; $display("FAIL win_pre: got %0d/L%0d want 82/L2", ifa.score, ifa.level); end
    idle(40);
    tests++; if (ifa.bcd !== 16'h0082) begin fails++; $display("FAIL win_bcd82: got %h want 0082", ifa.bcd); end
    ev_a(3'd4);
    tests++; if (ifa.score !== 13'd106 || ifa.level !== 4'd3) begin fails++; $display("FAIL win_score106: got %0d/L%0d want 106/L3", ifa.score, ifa.level); end
    tests++; if (ifa.win !== 1'b0) begin fails++; $display("FAIL win_lag: got %b want 0", ifa.win); end
    @(negedge clk);
    tests++; if (ifa.win !== 1'b1) begin fails++; $display("FAIL win_set: got %b want 1", ifa.win); end
    idle(1);
    gs_a();
    tests++; if (ifa.score !== 13'd0 || ifa.level !== 4'd0 || ifa.win !== 1'b1) begin fails++; $display("FAIL gs_clear: got %0d/L%0d/w%b want 0/L0/w1", ifa.score, ifa.level, ifa.win); end
    @(negedge clk);
    tests++; if (ifa.win !== 1'b0) begin fails++; $display("FAIL gs_win0: got %b want 0", ifa.win); end
    watch_bcd_a(40, cnt, f, l);
    tests++; if (cnt != 2 || f !== 16'h0106 || l !== 16'h0000) begin fails++; $display("FAIL gs_midconv: got %0d pulses %h..%h want 2 0106..0000", cnt, f, l); end
  endtask

  task automatic test_ignore();
    ev_a(3'd1);
    ev_a(3'd0);
    tests++; if (ifa.score !== 13'd1 || ifa.level !== 4'd0) begin fails++; $display("FAIL ign_lines0: got %0d/L%0d want 1/L0", ifa.score, ifa.level); end
    ev_a(3'd7);
    tests++; if (ifa.score !== 13'd1 || ifa.level !== 4'd0) begin fails++; $display("FAIL ign_lines7: got %0d/L%0d want 1/L0", ifa.score, ifa.level); end
    for (int i = 0; i < 8; i++) ev_a(3'd1);
    tests++; if (ifa.score !== 13'd9 || ifa.level !== 4'd0) begin fails++; $display("FAIL ign_lines9: got %0d/L%0d want 9/L0", ifa.score, ifa.level); end
    ev_a(3'd1);
    tests++; if (ifa.score !== 13'd10 || ifa.level !== 4'd1) begin fails++; $display("FAIL ign_lines10: got %0d/L%0d want 10/L1", ifa.score, ifa.level); end
    @(negedge clk); ifa.game_start = 1'b1; ifa.clr_valid = 1'b1; ifa.clr_lines = 3'd4;
    @(negedge clk); ifa.game_start = 1'b0; ifa.clr_valid = 1'b0; ifa.clr_lines = 3'd0;
    tests++; if (ifa.score !== 13'd0 || ifa.level !== 4'd0) begin fails++; $display("FAIL gs_coincident: got %0d/L%0d want 0/L0", ifa.score, ifa.level); end
    ev_a(3'd1);
    tests++; if (ifa.score !== 13'd1) begin fails++; $display("FAIL gs_after: got %0d want 1", ifa.score); end
  endtask

  task automatic test_back_to_back();
    int cnt; logic [15:0] f, l;
    idle(40);
    @(negedge clk); ifa.clr_valid = 1'b1; ifa.clr_lines = 3'd2;
    @(negedge clk); ifa.clr_valid = 1'b0; ifa.clr_lines = 3'd0;
    @(negedge clk);
    @(negedge clk); ifa.clr_valid = 1'b1; ifa.clr_lines = 3'd3;
    @(negedge clk); ifa.clr_valid = 1'b0; ifa.clr_lines = 3'd0;
    tests++; if (ifa.score !== 13'd9) begin fails++; $display("FAIL b2b_score: got %0d want 9", ifa.score); end
    watch_bcd_a(50, cnt, f, l);
    tests++; if (cnt != 2 || f !== 16'h0004 || l !== 16'h0009) begin fails++; $display("FAIL b2b_bcd: got %0d pulses %h..%h want 2 0004..0009", cnt, f, l); end
  endtask

  task automatic test_drop_tick();
    int gap[5] = '{20, 15, 10, 8, 8};
    int t0, t1;
    wait_tick_b(t0);
    tests++; if (t0 < 0) begin fails++; $display("FAIL tick_first: got timeout want tick"); end
    for (int k = 0; k < 5; k++) begin
      if (k < 4) ev_b(3'd1);
      wait_tick_b(t1);
      tests++; if (t1 < 0 || (t1 - t0) != gap[k]) begin fails++; $display("FAIL tick_gap%0d: got %0d want %0d", k, t1 - t0, gap[k]); end
      t0 = t1;
    end
    tests++; if (ifb.level !== 4'd4 || ifb.score !== 14'd10) begin fails++; $display("FAIL tick_level: got L%0d/%0d want L4/10", ifb.level, ifb.score); end
  endtask

  task automatic test_saturation();
    gs_b();
    tests++; if (ifb.score !== 14'd0 || ifb.level !== 4'd0) begin fails++; $display("FAIL sat_gs: got %0d/L%0d want 0/L0", ifb.score, ifb.level); end
    for (int i = 0; i < 15; i++) ev_b(3'd1);
    tests++; if (ifb.score !== 14'd120 || ifb.level !== 4'd15) begin fails++; $display("FAIL sat_climb: got %0d/L%0d want 120/L15", ifb.score, ifb.level); end
    ev_b(3'd1);
    tests++; if (ifb.score !== 14'd136 || ifb.level !== 4'd15) begin fails++; $display("FAIL sat_maxlevel: got %0d/L%0d want 136/L15", ifb.score, ifb.level); end
    for (int i = 0; i < 77; i++) ev_b(3'd4);
    tests++; if (ifb.score !== 14'd9992) begin fails++; $display("FAIL sat_near: got %0d want 9992", ifb.score); end
    ev_b(3'd4);
    tests++; if (ifb.score !== 14'd9999) begin fails++; $display("FAIL sat_clip: got %0d want 9999", ifb.score); end
    ev_b(3'd4);
    tests++; if (ifb.score !== 14'd9999) begin fails++; $display("FAIL sat_hold: got %0d want 9999", ifb.score); end
    idle(40);
    tests++; if (ifb.bcd !== 16'h9999) begin fails++; $display("FAIL sat_bcd: got %h want 9999", ifb.bcd); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ifa.game_start = 1'b0; ifa.clr_valid = 1'b0; ifa.clr_lines = 3'd0;
    ifb.game_start = 1'b0; ifb.clr_valid = 1'b0; ifb.clr_lines = 3'd0;
    test_reset();
    test_reset_abort();
    test_level_up();
    test_win();
    test_ignore();
    test_back_to_back();
    test_drop_tick();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
